coin_level_ctrl: RTL and testbench

COIN_LEVEL_CTRL -- requirements
Module: coin_level_ctrl

---
 rtl/level_pkg.sv | 18 +
 rtl/coin_touch.sv | 20 ++
 rtl/coin_level_ctrl.sv | 134 +++++++++++++
 tb/tb_coin_level_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// rtl/level_pkg.sv - tile codes, level state type and bit-count helper
package level_pkg;

  localparam logic [7:0] TILE_SKY = 8'd1;
  localparam logic [7:0] TILE_TKN = 8'd4;

  typedef enum logic [1:0] {PLAY, WON, LOST} level_state_t;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/coin_touch.sv
// rtl/coin_touch.sv - strict overlap of the sprite square with one coin tile
module coin_touch #(
  parameter int         CHARACTER_WIDTH = 42,
  parameter int         BLOCK_WIDTH     = 40,
  parameter logic [4:0] TILE_X          = 5'd0,
  parameter logic [3:0] TILE_Y          = 4'd0
) (
  input  int   mario_x,
  input  int   mario_y,
  output logic touch
);

  // Column 16 sits at the left edge and row 11 at the top of the screen.
  localparam int LEFT = (16 - int'(TILE_X)) * BLOCK_WIDTH;
  localparam int TOP  = (11 - int'(TILE_Y)) * BLOCK_WIDTH;

  assign touch = (mario_x < LEFT + BLOCK_WIDTH) && (mario_x + CHARACTER_WIDTH > LEFT) &&
                 (mario_y < TOP + BLOCK_WIDTH)  && (mario_y + CHARACTER_WIDTH > TOP);

endmodule

// File: rtl/coin_level_ctrl.sv
// rtl/coin_level_ctrl.sv - coin collection, win/lose FSM and tile erase queue
module coin_level_ctrl
  import level_pkg::*;
#(
  parameter int                     NUM_COINS       = 4,
  parameter logic [5*NUM_COINS-1:0] COIN_X          = {5'd15, 5'd12, 5'd8, 5'd3},
  parameter logic [4*NUM_COINS-1:0] COIN_Y          = {4'd3, 4'd3, 4'd5, 4'd7},
  parameter int                     TIME_LIMIT      = 60,
  parameter int                     CHARACTER_WIDTH = 42,
  parameter int                     BLOCK_WIDTH     = 40,
  parameter logic [7:0]             SKY             = TILE_SKY,
  parameter logic [7:0]             TKN             = TILE_TKN
) (
  input  logic                 vga_clock,
  input  logic                 reset,
  input  int                   mario_x,
  input  int                   mario_y,
  input  int                   seconds,
  output logic                 tile_wr_valid,
  input  logic                 tile_wr_ready,
  output logic [4:0]           tile_wr_x,
  output logic [3:0]           tile_wr_y,
  output logic [7:0]           tile_wr_code,
  output logic [NUM_COINS-1:0] collected,
  output logic [3:0]           coins_left,
  output logic                 win,
  output logic                 lose
);

  logic [NUM_COINS-1:0] touch_now;
  logic [NUM_COINS-1:0] touch_q;
  logic [NUM_COINS-1:0] pending;
  logic [NUM_COINS-1:0] new_hit;
  logic [NUM_COINS-1:0] clr_mask;
  logic [2:0]           low_idx;
  logic [2:0]           pres_idx;
  logic [2:0]           held_idx;
  logic                 held;
  logic                 low_found;
  logic [3:0]           hit_count;
  logic [3:0]           left_next;
  level_state_t         state;

  // The first listed coordinate belongs to coin 0.
  for (genvar g = 0; g < NUM_COINS; g++) begin : g_touch
    coin_touch #(
      .CHARACTER_WIDTH(CHARACTER_WIDTH),
      .BLOCK_WIDTH    (BLOCK_WIDTH),
      .TILE_X         (COIN_X[5*(NUM_COINS-1-g) +: 5]),
      .TILE_Y         (COIN_Y[4*(NUM_COINS-1-g) +: 4])
    ) u_touch (
      .mario_x(mario_x),
      .mario_y(mario_y),
      .touch  (touch_now[g])
    );
  end

  always_comb begin
    low_idx   = 3'd0;
    low_found = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (pending[i] && !low_found) begin
        low_idx   = 3'(i);
        low_found = 1'b1;
      end
    end
    // A stalled entry stays presented even if a lower-index coin arrives.
    pres_idx      = held ? held_idx : low_idx;
    tile_wr_valid = |pending;
    tile_wr_x     = 5'd0;
    tile_wr_y     = 4'd0;
    tile_wr_code  = 8'd0;
    clr_mask      = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (tile_wr_valid && pres_idx == 3'(i)) begin
        tile_wr_x    = COIN_X[5*(NUM_COINS-1-i) +: 5];
        tile_wr_y    = COIN_Y[4*(NUM_COINS-1-i) +: 4];
        tile_wr_code = SKY;
        clr_mask[i]  = tile_wr_ready;
      end
    end
    new_hit   = (state == PLAY) ? (touch_q & ~collected) : '0;
    hit_count = count_ones(8'(new_hit));
    left_next = coins_left - hit_count;
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state      <= PLAY;
      touch_q    <= '0;
      collected  <= '0;
      pending    <= '0;
      coins_left <= 4'(NUM_COINS);
      held       <= 1'b0;
      held_idx   <= 3'd0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      touch_q    <= touch_now;
      collected  <= collected | new_hit;
      pending    <= (pending & ~clr_mask) | new_hit;
      coins_left <= left_next;
      held       <= tile_wr_valid && !tile_wr_ready;
      if (tile_wr_valid && !tile_wr_ready) begin
        held_idx <= pres_idx;
      end
      case (state)
        PLAY: begin
          if (left_next == 4'd0) begin
            state <= WON;
            win   <= 1'b1;
          end else if (seconds >= TIME_LIMIT) begin
            state <= LOST;
            lose  <= 1'b1;
          end
        end
        WON: begin
          win  <= 1'b1;
          lose <= 1'b0;
        end
        LOST: begin
          win  <= 1'b0;
          lose <= 1'b1;
        end
        default: begin
          state <= PLAY;
          win   <= 1'b0;
          lose  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_level_ctrl.sv
// tb/tb_coin_level_ctrl.sv - scoreboard bench for coin_level_ctrl
module tb_coin_level_ctrl;

  localparam int N  = 4;
  localparam int CW = 42;
  localparam int BW = 40;
  localparam int TL = 60;

  int cx[N] = '{15, 12, 8, 3};
  int cy[N] = '{3, 3, 5, 7};

  logic         vga_clock = 1'b0;
  logic         reset = 1'b0;
  int           mario_x = 0;
  int           mario_y = 0;
  int           seconds = 0;
  logic         tile_wr_ready = 1'b1;
  logic         tile_wr_valid;
  logic [4:0]   tile_wr_x;
  logic [3:0]   tile_wr_y;
  logic [7:0]   tile_wr_code;
  logic [N-1:0] collected;
  logic [3:0]   coins_left;
  logic         win;
  logic         lose;

  always #5 vga_clock = ~vga_clock;

  coin_level_ctrl #(
    .NUM_COINS      (N),
    .COIN_X         ({5'd15, 5'd12, 5'd8, 5'd3}),
    .COIN_Y         ({4'd3, 4'd3, 4'd5, 4'd7}),
    .TIME_LIMIT     (TL),
    .CHARACTER_WIDTH(CW),
    .BLOCK_WIDTH    (BW),
    .SKY            (8'd1),
    .TKN            (8'd4)
  ) dut (
    .vga_clock    (vga_clock),
    .reset        (reset),
    .mario_x      (mario_x),
    .mario_y      (mario_y),
    .seconds      (seconds),
    .tile_wr_valid(tile_wr_valid),
    .tile_wr_ready(tile_wr_ready),
    .tile_wr_x    (tile_wr_x),
    .tile_wr_y    (tile_wr_y),
    .tile_wr_code (tile_wr_code),
    .collected    (collected),
    .coins_left   (coins_left),
    .win          (win),
    .lose         (lose)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit touches(input int i, input int mx, input int my);
    int l;
    int t;
    l = (16 - cx[i]) * BW;
    t = (11 - cy[i]) * BW;
    return (mx < l + BW) && (l < mx + CW) && (my < t + BW) && (t < my + CW);
  endfunction

  // Reference model: the game rules, one registered touch sample of delay.
  bit m_tq[N];
  bit m_col[N];
  int m_left;
  bit m_won;
  bit m_lost;
  int exp_q[$];

  always @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_tq[i]  = 1'b0;
        m_col[i] = 1'b0;
      end
      m_left = N;
      m_won  = 1'b0;
      m_lost = 1'b0;
      exp_q.delete();
    end else begin
      if (!m_won && !m_lost) begin
        for (int i = 0; i < N; i++) begin
          if (m_tq[i] && !m_col[i]) begin
            m_col[i] = 1'b1;
            m_left--;
            exp_q.push_back(i);
          end
        end
        if (m_left == 0) m_won = 1'b1;
        else if (seconds >= TL) m_lost = 1'b1;
      end
      for (int i = 0; i < N; i++) m_tq[i] = touches(i, mario_x, mario_y);
    end
  end

  // Monitor: compares every cycle and retires writes on handshake.
  bit presenting = 1'b0;
  int pres = 0;
  int wr_count = 0;

  always @(negedge vga_clock) begin
    if (!reset) begin
      presenting = 1'b0;
    end else begin
      logic [N-1:0] mc;
      for (int i = 0; i < N; i++) mc[i] = m_col[i];
      chk("coins_left", int'(coins_left), m_left);
      chk("collected", int'(collected), int'(mc));
      chk("win", int'(win), int'(m_won));
      chk("lose", int'(lose), int'(m_lost));
      chk("tile_wr_valid", int'(tile_wr_valid), int'(exp_q.size() != 0));
      if (tile_wr_valid && exp_q.size() != 0) begin
        if (!presenting) begin
          pres = exp_q[0];
          foreach (exp_q[k]) if (exp_q[k] < pres) pres = exp_q[k];
          presenting = 1'b1;
        end
        chk("tile_wr_x", int'(tile_wr_x), cx[pres]);
        chk("tile_wr_y", int'(tile_wr_y), cy[pres]);
        chk("tile_wr_code", int'(tile_wr_code), 1);
        if (tile_wr_ready) begin
          foreach (exp_q[k]) begin
            if (exp_q[k] == pres) begin
              exp_q.delete(k);
              break;
            end
          end
          presenting = 1'b0;
          wr_count++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge vga_clock);
      #1;
    end
  endtask

  task automatic place(input int mx, input int my, input int n);
    mario_x = mx;
    mario_y = my;
    step(n);
  endtask

  task automatic visit(input int i);
    place((16 - cx[i]) * BW, (11 - cy[i]) * BW, 1);
  endtask

  task automatic do_reset();
    mario_x = 0;
    mario_y = 0;
    seconds = 0;
    tile_wr_ready = 1'b1;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    wr_count = 0;
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    step(3);
    chk("rst_valid", int'(tile_wr_valid), 0);
    chk("rst_coins_left", int'(coins_left), 4);
    chk("rst_collected", int'(collected), 0);
    chk("rst_win_lose", int'({win, lose}), 0);
    chk("rst_x", int'(tile_wr_x), 0);
    reset = 1'b1;
    step(1);

    // Single coin: latency and one write.
    mario_x = 40;
    mario_y = 320;
    step(1);
    chk("lat_edge1_valid", int'(tile_wr_valid), 0);
    place(0, 0, 1);
    chk("lat_edge2_valid", int'(tile_wr_valid), 1);
    step(5);
    chk("c0_writes", wr_count, 1);
    chk("c0_collected", int'(collected), 1);
    chk("c0_left", int'(coins_left), 3);

    // Revisit collected coin.
    place(40, 320, 2);
    place(0, 0, 5);
    chk("revisit_writes", wr_count, 1);
    chk("revisit_left", int'(coins_left), 3);

    // Two coins with a stalled queue.
    do_reset();
    tile_wr_ready = 1'b0;
    visit(0);
    visit(1);
    place(0, 0, 5);
    chk("stall_valid", int'(tile_wr_valid), 1);
    chk("stall_x0", int'(tile_wr_x), 15);
    chk("stall_left", int'(coins_left), 2);
    tile_wr_ready = 1'b1;
    step(1);
    tile_wr_ready = 1'b0;
    step(2);
    chk("stall_x1", int'(tile_wr_x), 12);
    tile_wr_ready = 1'b1;
    step(3);
    chk("stall_writes", wr_count, 2);

    // Lower-index coin arriving during a stall must not displace the entry.
    do_reset();
    tile_wr_ready = 1'b0;
    visit(1);
    place(0, 0, 2);
    visit(0);
    place(0, 0, 3);
    chk("hold_x", int'(tile_wr_x), 12);
    tile_wr_ready = 1'b1;
    step(4);

    // Win, then time runs out.
    do_reset();
    seconds = 10;
    for (int i = 0; i < N; i++) visit(i);
    place(0, 0, 3);
    chk("win_flag", int'(win), 1);
    chk("win_nolose", int'(lose), 0);
    seconds = 70;
    step(3);
    chk("win_sticky", int'({win, lose}), 2);

    // Lose with one coin left, later touch ignored.
    do_reset();
    for (int i = 0; i < 3; i++) visit(i);
    seconds = 60;
    place(0, 0, 2);
    chk("lose_flag", int'(lose), 1);
    visit(3);
    place(0, 0, 3);
    chk("lose_left", int'(coins_left), 1);
    chk("lose_collected", int'(collected), 7);
    chk("lose_sticky", int'({win, lose}), 1);

    // Last coin and timeout on the same edge.
    do_reset();
    seconds = 50;
    for (int i = 0; i < 3; i++) visit(i);
    seconds = 59;
    visit(3);
    seconds = 60;
    place(0, 0, 3);
    chk("prio_win_lose", int'({win, lose}), 2);

    // Asynchronous reset with two writes pending.
    do_reset();
    tile_wr_ready = 1'b0;
    visit(0);
    visit(1);
    place(0, 0, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", int'(tile_wr_valid), 0);
    chk("arst_left", int'(coins_left), 4);
    chk("arst_win_lose", int'({win, lose}), 0);
    chk("arst_collected", int'(collected), 0);
    step(1);
    reset = 1'b1;
    tile_wr_ready = 1'b1;
    step(1);

    // Randomized episodes.
    for (int e = 0; e < 6; e++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        if (c % 4 == 0) seconds++;
        if ($urandom_range(1, 0) == 1) begin
          int i;
          i = int'($urandom_range(N - 1, 0));
          mario_x = (16 - cx[i]) * BW + int'($urandom_range(60, 0)) - 30;
          mario_y = (11 - cy[i]) * BW + int'($urandom_range(60, 0)) - 30;
        end else begin
          mario_x = int'($urandom_range(680, 0));
          mario_y = int'($urandom_range(480, 0));
        end
        tile_wr_ready = ($urandom_range(2, 0) != 0);
        step(1);
      end
      tile_wr_ready = 1'b1;
      place(0, 0, 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
